// File: rtl/wdt_reg_if_pkg.sv
// Shared definitions for the watchdog register front end.
// Holds the register offsets, the response FSM state type and the bit
// positions of the fields inside CTRL, KICK and STATUS.
package wdt_pkg;

    // Register offsets from the block base (byte addresses, word aligned)
    localparam logic [15:0] CTRL_OFF   = 16'h0100;
    localparam logic [15:0] KICK_OFF   = 16'h0200;
    localparam logic [15:0] TOCNT_OFF  = 16'h0300;
    localparam logic [15:0] STATUS_OFF = 16'h0400;

    // Request/response FSM
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } wdt_state_e;

    // Field positions
    localparam int CTRL_WDEN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT   = 1;
    localparam int KICK_BIT          = 0;
    localparam int STATUS_WTO_BIT    = 0;
    localparam int STATUS_STICKY_BIT = 1;

endpackage

// File: rtl/wdt_reg_if_if.sv
// Single-beat CPU register bus between a requester and the watchdog
// register front end.
//   master : drives req_valid/req_write/req_addr/req_wdata/req_wstrb and
//            rsp_ready; receives req_ready, rsp_valid, rsp_rdata, rsp_err.
//   slave  : the mirror image.
interface wdt_reg_bus_if #(
    parameter int ADDR_W = 16
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wstrb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/wdt_reg_if_sync2.sv
// Two-flop synchroniser with rising-edge detection for a slow status line
// coming from another clock domain.
//   clk, rst    : destination clock, synchronous active-high reset
//   async_in    : asynchronous input level
//   sync_out    : synchronised level
//   rise_pulse  : one-cycle pulse on a synchronised 0->1 transition
module wdt_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise_pulse
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchroniser chain plus one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            meta_r <= async_in;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign sync_out   = sync_r;
    assign rise_pulse = sync_r & ~prev_r;

endmodule

// File: rtl/wdt_reg_if.sv
// Register front end for the watchdog timer.
// Decodes single-beat register requests into WDEN / WDLIVE / WTOCNT,
// stretches kicks to LIVE_HOLD cycles and brings WTO back as a status bit
// with a sticky flag and a level interrupt.
//   clk, rst : clock, synchronous active-high reset
//   bus      : register request/response bus (slave side)
//   WDEN     : watchdog enable
//   WDLIVE   : stretched kick
//   WTOCNT   : timeout count
//   WTO      : timeout from the watchdog (asynchronous)
//   wdt_irq  : level interrupt, sticky && irq_en
module wdt_reg_if
    import wdt_pkg::*;
#(
    parameter int          ADDR_W    = 16,
    parameter int          LIVE_HOLD = 4,
    parameter logic [31:0] DEF_TOCNT = 32'h0000_FFFF
) (
    input  logic          clk,
    input  logic          rst,
    wdt_reg_bus_if.slave  bus,
    output logic          WDEN,
    output logic          WDLIVE,
    output logic [31:0]   WTOCNT,
    input  logic          WTO,
    output logic          wdt_irq
);

    localparam int CNT_W = $clog2(LIVE_HOLD + 1);

    wdt_state_e  state_r;
    logic        req_ready_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_rdata_r;
    logic        rsp_err_r;

    logic             wden_r;
    logic             irq_en_r;
    logic [31:0]      wtocnt_r;
    logic             sticky_r;
    logic [CNT_W-1:0] live_cnt_r;
    logic             wdlive_r;
    logic             wdt_irq_r;

    logic             wto_sync_s;
    logic             wto_rise_s;
    logic             accept_s;
    logic             aligned_s;
    logic             hit_ctrl_s;
    logic             hit_kick_s;
    logic             hit_tocnt_s;
    logic             hit_status_s;
    logic [31:0]      tocnt_merge_s;
    logic             wden_n_s;
    logic             irq_en_n_s;
    logic [31:0]      wtocnt_n_s;
    logic             sticky_n_s;
    logic [CNT_W-1:0] live_cnt_n_s;
    logic [31:0]      rdata_n_s;
    logic             err_n_s;

    wdt_sync2 u_wto_sync (
        .clk        (clk),
        .rst        (rst),
        .async_in   (WTO),
        .sync_out   (wto_sync_s),
        .rise_pulse (wto_rise_s)
    );

    assign accept_s     = bus.req_valid && req_ready_r;
    assign aligned_s    = (bus.req_addr[1:0] == 2'b00);
    assign hit_ctrl_s   = (bus.req_addr == ADDR_W'(CTRL_OFF));
    assign hit_kick_s   = (bus.req_addr == ADDR_W'(KICK_OFF));
    assign hit_tocnt_s  = (bus.req_addr == ADDR_W'(TOCNT_OFF));
    assign hit_status_s = (bus.req_addr == ADDR_W'(STATUS_OFF));

    // Byte-lane merge of the write data onto the current timeout count
    always_comb begin
        tocnt_merge_s = wtocnt_r;
        for (int b = 0; b < 4; b++) begin
            if (bus.req_wstrb[b]) begin
                tocnt_merge_s[8*b +: 8] = bus.req_wdata[8*b +: 8];
            end else begin
                tocnt_merge_s[8*b +: 8] = wtocnt_r[8*b +: 8];
            end
        end
    end

    // Register access decode: next register values and response contents
    always_comb begin
        wden_n_s   = wden_r;
        irq_en_n_s = irq_en_r;
        wtocnt_n_s = wtocnt_r;
        sticky_n_s = sticky_r;
        rdata_n_s  = 32'd0;
        err_n_s    = 1'b0;
        if (live_cnt_r != {CNT_W{1'b0}}) begin
            live_cnt_n_s = live_cnt_r - CNT_W'(1);
        end else begin
            live_cnt_n_s = live_cnt_r;
        end

        if (accept_s) begin
            if (!aligned_s) begin
                err_n_s = 1'b1;
            end else if (hit_ctrl_s) begin
                if (!bus.req_write) begin
                    rdata_n_s[CTRL_WDEN_BIT]   = wden_r;
                    rdata_n_s[CTRL_IRQ_EN_BIT] = irq_en_r;
                end else if (bus.req_wstrb[0]) begin
                    wden_n_s   = bus.req_wdata[CTRL_WDEN_BIT];
                    irq_en_n_s = bus.req_wdata[CTRL_IRQ_EN_BIT];
                    // Disabling drops any stretch in progress
                    if (!bus.req_wdata[CTRL_WDEN_BIT]) begin
                        live_cnt_n_s = {CNT_W{1'b0}};
                    end else begin
                        live_cnt_n_s = live_cnt_n_s;
                    end
                end else begin
                    wden_n_s = wden_r;
                end
            end else if (hit_kick_s) begin
                if (!bus.req_write) begin
                    rdata_n_s[KICK_BIT] = (live_cnt_r != {CNT_W{1'b0}});
                end else if (bus.req_wstrb[0] && bus.req_wdata[KICK_BIT] && wden_r) begin
                    live_cnt_n_s = CNT_W'(LIVE_HOLD);
                end else begin
                    live_cnt_n_s = live_cnt_n_s;
                end
            end else if (hit_tocnt_s) begin
                if (!bus.req_write) begin
                    rdata_n_s = wtocnt_r;
                end else if (wden_r || (tocnt_merge_s == 32'd0)) begin
                    err_n_s = 1'b1;
                end else begin
                    wtocnt_n_s = tocnt_merge_s;
                end
            end else if (hit_status_s) begin
                if (!bus.req_write) begin
                    rdata_n_s[STATUS_WTO_BIT]    = wto_sync_s;
                    rdata_n_s[STATUS_STICKY_BIT] = sticky_r;
                end else if (bus.req_wstrb[0] && bus.req_wdata[STATUS_STICKY_BIT]) begin
                    sticky_n_s = 1'b0;
                end else begin
                    sticky_n_s = sticky_r;
                end
            end else begin
                err_n_s = 1'b1;
            end
        end else begin
            err_n_s = 1'b0;
        end

        // A new timeout edge overrides a simultaneous clear
        if (wto_rise_s) begin
            sticky_n_s = 1'b1;
        end else begin
            sticky_n_s = sticky_n_s;
        end
    end

    // Request/response FSM with registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'd0;
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r     <= RESP;
                        req_ready_r <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        rsp_rdata_r <= rdata_n_s;
                        rsp_err_r   <= err_n_s;
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state_r     <= IDLE;
                        req_ready_r <= 1'b1;
                        rsp_valid_r <= 1'b0;
                        rsp_rdata_r <= 32'd0;
                        rsp_err_r   <= 1'b0;
                    end else begin
                        req_ready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    req_ready_r <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    rsp_rdata_r <= 32'd0;
                    rsp_err_r   <= 1'b0;
                end
            endcase
        end
    end

    // Control/status registers and the registered watchdog-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            wden_r     <= 1'b0;
            irq_en_r   <= 1'b0;
            wtocnt_r   <= DEF_TOCNT;
            sticky_r   <= 1'b0;
            live_cnt_r <= {CNT_W{1'b0}};
            wdlive_r   <= 1'b0;
            wdt_irq_r  <= 1'b0;
        end else begin
            wden_r     <= wden_n_s;
            irq_en_r   <= irq_en_n_s;
            wtocnt_r   <= wtocnt_n_s;
            sticky_r   <= sticky_n_s;
            live_cnt_r <= live_cnt_n_s;
            wdlive_r   <= (live_cnt_r != {CNT_W{1'b0}});
            // Built from next values so the interrupt tracks sticky/irq_en edge for edge
            wdt_irq_r  <= sticky_n_s && irq_en_n_s;
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_err   = rsp_err_r;
    assign WDEN          = wden_r;
    assign WDLIVE        = wdlive_r;
    assign WTOCNT        = wtocnt_r;
    assign wdt_irq       = wdt_irq_r;

endmodule

// File: tb/tb_wdt_reg_if.sv
// Directed self-checking bench for wdt_reg_if.
module tb_wdt_reg_if;
    import wdt_pkg::*;

    logic        clk;
    logic        rst;
    logic        WDEN;
    logic        WDLIVE;
    logic [31:0] WTOCNT;
    logic        WTO;
    logic        wdt_irq;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rd;
    logic        er;

    wdt_reg_bus_if #(.ADDR_W(16)) bus ();

    wdt_reg_if #(
        .ADDR_W    (16),
        .LIVE_HOLD (4),
        .DEF_TOCNT (32'h0000_FFFF)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .WDEN    (WDEN),
        .WDLIVE  (WDLIVE),
        .WTOCNT  (WTOCNT),
        .WTO     (WTO),
        .wdt_irq (wdt_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request from a negedge; returns at the negedge after accept
    task automatic do_req(input string tag, input logic wr, input logic [15:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          output logic [31:0] rdata, output logic err);
        int n;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_wstrb = wstrb;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accept"}, {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
    endtask

    initial begin
        int n;
        rst           = 1'b1;
        WTO           = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 16'h0000;
        bus.req_wdata = 32'd0;
        bus.req_wstrb = 4'h0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_wden", {31'd0, WDEN}, 32'd0);
        check("rst_wdlive", {31'd0, WDLIVE}, 32'd0);
        check("rst_irq", {31'd0, wdt_irq}, 32'd0);
        check("rst_wtocnt", WTOCNT, 32'h0000_FFFF);
        rst = 1'b0;
        @(negedge clk);

        do_req("rd_tocnt_def", 1'b0, 16'h0300, 32'd0, 4'hF, rd, er);
        check("rd_tocnt_def_data", rd, 32'h0000_FFFF);
        check("rd_tocnt_def_err", {31'd0, er}, 32'd0);

        // TOCNT load, enable, then a locked-out TOCNT write
        do_req("wr_tocnt100", 1'b1, 16'h0300, 32'd100, 4'hF, rd, er);
        check("wr_tocnt100_err", {31'd0, er}, 32'd0);
        do_req("wr_ctrl3", 1'b1, 16'h0100, 32'h3, 4'hF, rd, er);
        check("wr_ctrl3_err", {31'd0, er}, 32'd0);
        do_req("wr_tocnt_locked", 1'b1, 16'h0300, 32'd5, 4'hF, rd, er);
        check("wr_tocnt_locked_err", {31'd0, er}, 32'd1);
        check("wr_tocnt_locked_rdata", rd, 32'd0);
        check("wtocnt_kept100", WTOCNT, 32'd100);
        check("wden_on", {31'd0, WDEN}, 32'd1);

        // Single kick: high for exactly 4 cycles starting one cycle late
        do_req("kick1", 1'b1, 16'h0200, 32'h1, 4'h1, rd, er);
        check("kick1_wdlive_c0", {31'd0, WDLIVE}, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("kick1_wdlive_high", {31'd0, WDLIVE}, 32'd1);
        end
        @(negedge clk);
        check("kick1_wdlive_low", {31'd0, WDLIVE}, 32'd0);

        // Back-to-back kicks reload the stretch: 6 continuous high samples
        do_req("kick2a", 1'b1, 16'h0200, 32'h1, 4'h1, rd, er);
        check("kick2_wdlive_c0", {31'd0, WDLIVE}, 32'd0);
        bus.req_valid = 1'b1;
        @(negedge clk);
        check("kick2_wdlive_c1", {31'd0, WDLIVE}, 32'd1);
        check("kick2_ready_c1", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("kick2b_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check("kick2_wdlive_c2", {31'd0, WDLIVE}, 32'd1);
        for (int i = 3; i <= 6; i++) begin
            @(negedge clk);
            check("kick2_wdlive_high", {31'd0, WDLIVE}, 32'd1);
        end
        @(negedge clk);
        check("kick2_wdlive_low", {31'd0, WDLIVE}, 32'd0);

        // Response back-pressure
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 16'h0300;
        @(negedge clk);
        check("stall_rsp_valid0", {31'd0, bus.rsp_valid}, 32'd1);
        bus.req_addr = 16'h0100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check("stall_rdata", bus.rsp_rdata, 32'd100);
            check("stall_req_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("stall_rel_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("stall_rel_req_ready", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("stall_next_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check("stall_next_rdata", bus.rsp_rdata, 32'h3);

        // Disable during a stretch cuts WDLIVE one cycle after the write
        @(negedge clk);
        do_req("kick3", 1'b1, 16'h0200, 32'h1, 4'h1, rd, er);
        do_req("wr_ctrl2", 1'b1, 16'h0100, 32'h2, 4'hF, rd, er);
        check("dis_wdlive_c0", {31'd0, WDLIVE}, 32'd1);
        @(negedge clk);
        check("dis_wdlive_c1", {31'd0, WDLIVE}, 32'd0);
        check("dis_wden", {31'd0, WDEN}, 32'd0);

        // Zero TOCNT, byte-lane TOCNT, unmapped/misaligned, strobe-less CTRL
        do_req("wr_tocnt0", 1'b1, 16'h0300, 32'd0, 4'hF, rd, er);
        check("wr_tocnt0_err", {31'd0, er}, 32'd1);
        check("wr_tocnt0_keep", WTOCNT, 32'd100);
        do_req("wr_tocnt_b1", 1'b1, 16'h0300, 32'h1234_AB56, 4'b0010, rd, er);
        check("wr_tocnt_b1_err", {31'd0, er}, 32'd0);
        check("wr_tocnt_b1_val", WTOCNT, 32'h0000_AB64);
        do_req("rd_unmapped", 1'b0, 16'h0500, 32'd0, 4'hF, rd, er);
        check("rd_unmapped_err", {31'd0, er}, 32'd1);
        check("rd_unmapped_rdata", rd, 32'd0);
        do_req("rd_misaligned", 1'b0, 16'h0302, 32'd0, 4'hF, rd, er);
        check("rd_misaligned_err", {31'd0, er}, 32'd1);
        check("rd_misaligned_rdata", rd, 32'd0);
        do_req("wr_ctrl_nostrb", 1'b1, 16'h0100, 32'h1, 4'h0, rd, er);
        check("wr_ctrl_nostrb_err", {31'd0, er}, 32'd0);
        check("wr_ctrl_nostrb_wden", {31'd0, WDEN}, 32'd0);
        do_req("kick_dis", 1'b1, 16'h0200, 32'h1, 4'h1, rd, er);
        @(negedge clk);
        check("kick_dis_wdlive", {31'd0, WDLIVE}, 32'd0);
        do_req("rd_kick_dis", 1'b0, 16'h0200, 32'd0, 4'hF, rd, er);
        check("rd_kick_dis_data", rd, 32'd0);

        // WTO rising edge raises sticky and the interrupt
        @(negedge clk);
        #2 WTO = 1'b1;
        n = 0;
        while (!wdt_irq && n < 3) begin
            @(negedge clk);
            n++;
        end
        check("wto_irq", {31'd0, wdt_irq}, 32'd1);
        do_req("rd_status3", 1'b0, 16'h0400, 32'd0, 4'hF, rd, er);
        check("rd_status3_data", rd, 32'h3);
        do_req("w1c", 1'b1, 16'h0400, 32'h2, 4'h1, rd, er);
        check("w1c_irq", {31'd0, wdt_irq}, 32'd0);
        do_req("rd_status1", 1'b0, 16'h0400, 32'd0, 4'hF, rd, er);
        check("rd_status1_data", rd, 32'h1);

        // W1C coincident with a new rising edge: set wins
        WTO = 1'b0;
        repeat (4) @(negedge clk);
        WTO = 1'b1;
        repeat (2) @(negedge clk);
        do_req("w1c_race", 1'b1, 16'h0400, 32'h2, 4'h1, rd, er);
        do_req("rd_status_race", 1'b0, 16'h0400, 32'd0, 4'hF, rd, er);
        check("rd_status_race_data", rd, 32'h3);
        check("race_irq", {31'd0, wdt_irq}, 32'd1);

        // Reset while a response is pending
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 16'h0300;
        @(negedge clk);
        check("mid_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("mid_rst_wtocnt", WTOCNT, 32'h0000_FFFF);
        check("mid_rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        check("mid_rst_irq", {31'd0, wdt_irq}, 32'd0);
        rst           = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        do_req("rd_after_rst", 1'b0, 16'h0100, 32'd0, 4'hF, rd, er);
        check("rd_after_rst_ctrl", rd, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wdt_reg_if.md
Name: wdt_reg_if

Overview:
Memory-mapped register front end for the watchdog timer; sits directly upstream of it on the CPU-side clock. Decodes single-beat CPU register requests into the watchdog's WDEN, WDLIVE and WTOCNT controls. Stretches kick pulses so the watchdog's slower clock domain cannot miss them. Synchronises the returned WTO back into this domain as a status bit and interrupt.

Parameters:
ADDR_W, 16, request address width (byte address, word-aligned registers)
LIVE_HOLD, 4, cycles WDLIVE stays high after one kick write (must be >= 1)
DEF_TOCNT, 32'h0000_FFFF, reset value of WTOCNT (non-zero)

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  synchronous, active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  byte address
req_wdata  in  32  write data
req_wstrb  in  4  byte-lane write enables
rsp_valid  out  1  response valid; held until rsp_ready
rsp_ready  in  1  response consumed
rsp_rdata  out  32  read data; 0 on writes and errors
rsp_err  out  1  response error flag
WDEN  out  1  watchdog enable
WDLIVE  out  1  watchdog kick, stretched
WTOCNT  out  32  timeout count
WTO  in  1  timeout from watchdog; asynchronous to clk
wdt_irq  out  1  level interrupt to the CPU

Behaviour:
- Clock/reset: one clock (clk); reset rst is synchronous, active-high.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, WDEN=0, WDLIVE=0, irq_en=0, sticky=0, live_cnt=0, WTOCNT=DEF_TOCNT. Synchroniser flops are cleared.
- FSM states: IDLE, RESP.
  - IDLE: req_ready=1. On handshake, execute the access and go to RESP. Register updates take effect at that edge.
  - RESP: rsp_valid=1 with rdata/err stable. On rsp_ready, go to IDLE.
  - Latency: response appears 1 cycle after accept. Maximum throughput is 1 request per 2 cycles.
- Register map (offsets from block base):
  - 0x0100 CTRL: bit0 WDEN, bit1 irq_en.
  - 0x0200 KICK: write bit0=1 triggers a kick. Read bit0 returns (live_cnt!=0).
  - 0x0300 TOCNT: 32-bit WTOCNT.
  - 0x0400 STATUS: bit0 = synchronised WTO (read-only). bit1 = sticky timeout flag; writing 1 clears it (W1C).
- Error rules:
  - Unmapped address or req_addr[1:0]!=0: rsp_err=1, rdata=0, no state change.
  - TOCNT write while WDEN=1: rsp_err=1, value ignored.
  - TOCNT write whose resulting value is 0: rsp_err=1, register unchanged.
- Byte strobes:
  - TOCNT honours all four byte lanes.
  - CTRL, KICK and STATUS act only when req_wstrb[0]=1; otherwise the write is a no-op with no error.
- Kick: accepted KICK write with bit0=1 while WDEN=1 loads live_cnt=LIVE_HOLD.
  - WDLIVE = (live_cnt!=0), registered. It rises the cycle after the accept edge.
  - live_cnt decrements by 1 per cycle while non-zero.
  - Kick while live_cnt!=0 reloads the count, giving a continuous high.
  - Kick while WDEN=0 is accepted with no effect.
- Disable: writing WDEN=0 clears live_cnt at the same edge, so WDLIVE drops the next cycle.
- WTO path:
  - 2-flop synchroniser, then rising-edge detect.
  - A rising edge sets sticky. If set and W1C clear occur in the same cycle, set wins.
  - wdt_irq = sticky && irq_en, registered.
- Reset mid-transaction: the pending response is discarded. Outputs return to reset values the cycle after rst is sampled high.

Decomposition:
- Package wdt_pkg holds:
  - the register offset localparams (CTRL/KICK/TOCNT/STATUS);
  - the FSM state enum {IDLE, RESP};
  - the CTRL/STATUS bit-index constants.
- One sub-module, wdt_sync2: 2-flop synchroniser plus rising-edge pulse. It is reusable for other cross-domain status lines.

Test Plan:
- Reset, then read TOCNT -> rsp_rdata=32'h0000_FFFF, rsp_err=0. WDEN=0, WDLIVE=0, wdt_irq=0.
- Write TOCNT=32'd100, then CTRL=32'h3, then attempt TOCNT=32'd5 -> WTOCNT stays 100, the third response has rsp_err=1, WDEN=1.
- With WDEN=1, write KICK=1 -> WDLIVE high for exactly 4 consecutive cycles starting 1 cycle after accept. A second kick at cycle 2 -> WDLIVE high continuously through cycle 2+4.
- Hold rsp_ready=0 for 5 cycles after a read -> rsp_valid and rsp_rdata stable throughout, req_ready=0. Next request is accepted only after the rsp handshake.
- Drive WTO 0->1 asynchronously with irq_en=1 -> STATUS reads 32'h3 and wdt_irq=1 within 3 cycles. W1C write 32'h2 -> bit1 clears, wdt_irq drops. W1C coincident with a new rising edge -> sticky stays 1.
- Read 0x0500, and write TOCNT with wdata=0 -> rsp_err=1, rdata=0, WTOCNT unchanged. Assert rst while in RESP -> rsp_valid=0 and WTOCNT=DEF_TOCNT next cycle.
